scratch_stack_ctrl: RTL and testbench

// - Sequences the CPU scratch/data stack: a single-port synchronous block RAM (1-cycle registered read).
// - Owns the stack pointer.
// - Serves PUSH, POP and PEEK requests over a valid/ready handshake, so the CPU FSM no longer hand-times
//   RAM write-enable pulses or read wait states.
// - Flags overflow and underflow.

---
 rtl/scratch_stack_ctrl_pkg.sv | 21 ++
 rtl/stack_ram.sv | 27 ++
 rtl/scratch_stack_ctrl.sv | 124 ++++++++++++
 tb/tb_scratch_stack_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/scratch_stack_ctrl_pkg.sv
// Shared encodings and default widths for the scratch-stack controller.
package scratch_stack_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10,
    ST_RSP  = 2'b11
  } state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous RAM, write-first, registered read, no reset so it maps
// onto FPGA block RAM.
module stack_ram
  import scratch_stack_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  logic [DATA_W-1:0] r_mem [(1<<ADDR_W)];

  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      r_mem[i_addr] <= i_din;
      o_dout        <= i_din;
    end else begin
      o_dout <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/scratch_stack_ctrl.sv
// Stack-pointer owner and request sequencer for the CPU scratch stack RAM.
// States: IDLE accept | WR bump depth after write | RD RAM read settling | RSP response pulse.
module scratch_stack_ctrl
  import scratch_stack_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W:0]   depth,
  output logic              empty,
  output logic              full,
  output logic              err_overflow,
  output logic              err_underflow,
  input  logic              err_clr
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W:0]     r_depth;
  logic                r_is_pop;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_ovf;
  logic                r_unf;
  logic                w_wen;
  logic                w_set_ovf;
  logic                w_set_unf;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_dout;

  assign empty = (r_depth == '0);
  assign full  = (r_depth == {1'b1, {ADDR_W{1'b0}}});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wen       = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && (req_op != OP_NOP)) begin
          if (req_op == OP_PUSH) begin
            if (full) begin
              w_set_ovf = 1'b1;
            end else begin
              w_wen       = 1'b1;
              w_state_nxt = ST_WR;
            end
          end else if (empty) begin
            // underflow still answers (with zero) so the requester never stalls
            w_set_unf   = 1'b1;
            w_state_nxt = ST_RSP;
          end else begin
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_WR:   w_state_nxt = ST_IDLE;
      ST_RD:   w_state_nxt = ST_RSP;
      ST_RSP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Writes target the next free slot; reads target the top of stack.
  assign w_addr = w_wen ? r_depth[ADDR_W-1:0] : (r_depth[ADDR_W-1:0] - ADDR_W'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_depth     <= '0;
      r_is_pop    <= 1'b0;
      r_rsp_rdata <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      if (r_state == ST_WR)
        r_depth <= r_depth + (ADDR_W+1)'(1);
      else if ((r_state == ST_RSP) && r_is_pop)
        r_depth <= r_depth - (ADDR_W+1)'(1);

      if (r_state == ST_IDLE)
        r_is_pop <= (w_state_nxt == ST_RD) && (req_op == OP_POP);

      if (w_set_unf)
        r_rsp_rdata <= '0;
      else if (r_state == ST_RD)
        r_rsp_rdata <= w_dout;

      r_ovf <= w_set_ovf | (r_ovf & ~err_clr);
      r_unf <= w_set_unf | (r_unf & ~err_clr);
    end
  end

  stack_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk (clk),
    .i_wen (w_wen),
    .i_addr(w_addr),
    .i_din (req_wdata),
    .o_dout(w_dout)
  );

  assign req_ready     = (r_state == ST_IDLE);
  assign rsp_valid     = (r_state == ST_RSP);
  assign rsp_rdata     = r_rsp_rdata;
  assign depth         = r_depth;
  assign err_overflow  = r_ovf;
  assign err_underflow = r_unf;

endmodule

// File: tb/tb_scratch_stack_ctrl.sv
// Directed plus randomized bench for scratch_stack_ctrl against a queue-based stack model.
module tb_scratch_stack_ctrl;

  localparam int DEPTH = 256;
  localparam logic [1:0] T_NOP = 2'b00, T_PUSH = 2'b01, T_POP = 2'b10, T_PEEK = 2'b11;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_wdata = 32'h0;
  logic        err_clr = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [8:0]  depth;
  logic        empty;
  logic        full;
  logic        err_overflow;
  logic        err_underflow;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] q[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  logic [31:0] m_last = 32'h0;

  always #5 clk = ~clk;

  scratch_stack_ctrl #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .depth        (depth),
    .empty        (empty),
    .full         (full),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .err_clr      (err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(req_ready), 64'(1));
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_depth"}, 64'(depth), 64'(q.size()));
    chk({tag, "_empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, "_full"}, 64'(full), 64'(q.size() == DEPTH));
    chk({tag, "_ovf"}, 64'(err_overflow), 64'(m_ovf));
    chk({tag, "_unf"}, 64'(err_underflow), 64'(m_unf));
    chk({tag, "_rdata_hold"}, 64'(rsp_rdata), 64'(m_last));
    chk({tag, "_rsp_idle"}, 64'(rsp_valid), 64'(0));
  endtask

  // Issue one request at a falling edge and follow it to completion.
  task automatic issue(input logic [1:0] op, input logic [31:0] d, input bit clr, input string tag);
    bit          resp = 1'b0;
    bit          busy = 1'b0;
    bit          set_o = 1'b0;
    bit          set_u = 1'b0;
    int          lat = 0;
    logic [31:0] exp_d = 32'h0;
    wait_ready();
    case (op)
      T_PUSH: begin
        if (q.size() == DEPTH) set_o = 1'b1;
        else begin q.push_back(d); busy = 1'b1; end
      end
      T_POP, T_PEEK: begin
        busy = 1'b1;
        resp = 1'b1;
        if (q.size() == 0) begin
          set_u = 1'b1; lat = 1; exp_d = 32'h0;
        end else begin
          lat = 2;
          exp_d = (op == T_POP) ? q.pop_back() : q[$];
        end
      end
      default: ;
    endcase
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (set_o) m_ovf = 1'b1;
    if (set_u) m_unf = 1'b1;
    if (resp) m_last = exp_d;

    req_valid = 1'b1; req_op = op; req_wdata = d; err_clr = clr;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_wdata = $urandom; err_clr = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(resp && c == lat));
      if (resp && c == lat) chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(exp_d));
      if (c == 1) chk({tag, "_ready_after_accept"}, 64'(req_ready), 64'(!busy));
    end
    wait_ready();
    check_status(tag);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'(1));
    resetn = 1'b1;
    @(negedge clk);
    check_status("reset");

    // back-to-back pushes with req_valid held high
    req_valid = 1'b1; req_op = T_PUSH; req_wdata = 32'h11;
    for (int k = 0; k < 3; k++) begin
      chk("b2b_ready", 64'(req_ready), 64'(1));
      q.push_back(req_wdata);
      @(posedge clk);
      #1;
      if (k == 0) req_wdata = 32'h22;
      else if (k == 1) req_wdata = 32'h33;
      else req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    check_status("b2b");

    repeat (3) issue(T_POP, 32'h0, 1'b0, "pop3");

    issue(T_PUSH, 32'hDEADBEEF, 1'b0, "push_db");
    issue(T_PEEK, 32'h0, 1'b0, "peek_db1");
    issue(T_PEEK, 32'h0, 1'b0, "peek_db2");
    issue(T_POP, 32'h0, 1'b0, "pop_db");

    issue(T_POP, 32'h0, 1'b0, "underflow");
    err_clr = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check_status("err_clr");
    issue(T_POP, 32'h0, 1'b1, "clr_vs_set");

    for (int i = 0; i < DEPTH; i++) issue(T_PUSH, 32'(i), 1'b0, "fill");
    issue(T_PUSH, 32'hFF, 1'b0, "overflow");
    for (int i = 0; i < DEPTH; i++) issue(T_POP, 32'h0, 1'b0, "drain");

    // reset while a POP sits in RD
    issue(T_PUSH, 32'h5, 1'b0, "pre_abort");
    req_valid = 1'b1; req_op = T_POP;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_rd", 64'(req_ready), 64'(0));
    resetn = 1'b0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_last = 32'h0;
    #1;
    chk("abort_depth", 64'(depth), 64'(0));
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(rsp_valid), 64'(0));
    end
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_rel_no_rsp", 64'(rsp_valid), 64'(0));
      chk("abort_rel_ready", 64'(req_ready), 64'(1));
    end
    check_status("abort");
    issue(T_POP, 32'h0, 1'b0, "post_abort_pop");

    // randomized traffic from empty, then near full
    for (int i = 0; i < 80; i++)
      issue(2'($urandom), $urandom, ($urandom_range(0, 15) == 0), "rand_lo");
    while (q.size() < DEPTH - 4) issue(T_PUSH, $urandom, 1'b0, "prefill");
    for (int i = 0; i < 150; i++)
      issue(2'($urandom), $urandom, ($urandom_range(0, 15) == 0), "rand_hi");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
